power_monitor: RTL and testbench
================================

POWER_MONITOR -- requirements
Module: power_monitor

Interface
REQ-001 Parameter SETTLE_CYCLES, default 10'd512, cycles waited after each sel change before sampling data.
REQ-002 Parameter NUM_CH, default 7, number of monitored channels (sel values 0..NUM_CH-1).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sel  input  3  channel select driven by the power-management stage.
REQ-006 data  input  1  comparator result for the selected channel.
REQ-007 kill_sw  input  1  power-switch state from the power-management stage; 1 = power on, monitoring enabled.
REQ-008 clear  input  1  single-cycle host pulse; clears fault and fault_ch.
REQ-009 status  output  7  per-channel good flag; bit n = 1 when channel n passed its last check.
REQ-010 status_valid  output  1  high once every channel has been checked since enable.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_ch  output  3  channel of the first fault since the last clear.
REQ-013 scan_count  output  16  count of completed full scans (channel NUM_CH-1 checked).

Function
REQ-014 States are IDLE, SETTLE, SAMPLE, WAIT; the block powers up in IDLE.
REQ-015 IDLE: kill_sw=1 moves the block to SETTLE, latches sel, loads the settle counter with 0, and clears the seen mask.
REQ-016 SETTLE: the counter increments each cycle; count == SETTLE_CYCLES-1 moves the block to SAMPLE.
REQ-017 SAMPLE: data is captured on 3 consecutive cycles; the majority value is the channel result; after the third sample the block moves to WAIT.
REQ-018 Pass rule: an even channel passes when the result is 1; an odd channel passes when the result is 0.
REQ-019 The result is written to status[latched sel] exactly one cycle after the third sample, and the matching seen-mask bit is set.
REQ-020 WAIT: sel != latched sel relatches sel and restarts SETTLE with the counter at 0.
REQ-021 A sel change during SETTLE or SAMPLE aborts the check: no status write, SETTLE restarts on the new sel.
REQ-022 sel >= NUM_CH is ignored: no check, no status write, the block stays in WAIT.
REQ-023 status_valid = 1 when all NUM_CH seen bits are set; it is cleared on re-entry from IDLE.
REQ-024 A failing check sets fault; if fault was 0 the same cycle, fault_ch is set to the channel.
REQ-025 clear and a new failing check in the same cycle: the fault wins (fault=1, fault_ch = new channel).
REQ-026 scan_count increments on each completed check of channel NUM_CH-1 and saturates at 16'hFFFF.
REQ-027 kill_sw=0 in any state returns the block to IDLE next cycle; status, fault, fault_ch and scan_count are held.

Reset
REQ-028 reset_n low: state=IDLE and all counters = 0; outputs are status=0, status_valid=0, fault=0, fault_ch=0, scan_count=0.
REQ-029 Reset is asserted asynchronously and released synchronously to clk through a 2-flop synchroniser.

Configuration
REQ-030 With POWER_MONITOR_FAULT_LOG_EN defined, an extra output fault_scan[15:0] captures scan_count when fault_ch is captured; it resets to 0 and is cleared by clear.
REQ-031 Without POWER_MONITOR_FAULT_LOG_EN, the fault_scan port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 The shared package power_pkg holds the state enum, NUM_CH_DEFAULT=7, and the pass-rule polarity constant (EVEN_EXPECT=1).
REQ-033 The 3-sample majority voter is a sub-module, power_monitor_vote (data, sample strobe, result, result_valid).

Verification
REQ-034 SETTLE_CYCLES=4; kill_sw=1; sel steps 0..6, holding 10 cycles each, data=1 on even and 0 on odd -> status=7'h7F, status_valid=1, fault=0, scan_count=1.
REQ-035 Same sweep with data=0 on sel=2 -> status[2]=0, fault=1, fault_ch=2; a clear pulse -> fault=0, status unchanged.
REQ-036 Glitch: on sel=1, data samples 0,1,0 -> majority 0, pass; samples 1,0,1 -> fail, fault_ch=1.
REQ-037 sel changes 2 cycles into SETTLE -> no status write for the old channel; the new channel is checked normally.
REQ-038 kill_sw dropped mid-SAMPLE -> IDLE next cycle, status held; reset_n pulsed low mid-scan -> all outputs 0 immediately.
REQ-039 Failing check coincident with clear -> fault=1 and fault_ch = failing channel; with POWER_MONITOR_FAULT_LOG_EN, fault_scan equals scan_count at capture.

Source files
------------

// File: rtl/power_pkg.sv
// power_pkg: types and constants shared by the power_monitor block,
// its bus interface and its majority-vote sub-module.
package power_pkg;

   // Monitor sequencing states; IDLE is the power-up state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_WAIT   = 2'd3
   } state_t;

   localparam int NUM_CH_DEFAULT = 7;

   // Comparator level that means "good" on an even channel; odd channels
   // are wired with the opposite polarity.
   localparam logic EVEN_EXPECT = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic expect_level(input logic odd_ch);
      return odd_ch ? ~EVEN_EXPECT : EVEN_EXPECT;
   endfunction

endpackage

// File: rtl/power_monitor_if.sv
// power_monitor_if: channel-select / comparator inputs from the
// power-management stage, host clear, and the monitor's status outputs.
// Optional macro POWER_MONITOR_FAULT_LOG_EN adds the fault_scan field.
interface power_monitor_if
   import power_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT
) ();
   logic [2:0]        sel;
   logic              data;
   logic              kill_sw;
   logic              clear;
   logic [NUM_CH-1:0] status;
   logic              status_valid;
   logic              fault;
   logic [2:0]        fault_ch;
   logic [15:0]       scan_count;
`ifdef POWER_MONITOR_FAULT_LOG_EN
   logic [15:0]       fault_scan;
`endif
   state_t            state;

   modport slave (
      input  sel, data, kill_sw, clear,
      output status, status_valid, fault, fault_ch, scan_count,
`ifdef POWER_MONITOR_FAULT_LOG_EN
      output fault_scan,
`endif
      output state
   );

   modport master (
      output sel, data, kill_sw, clear,
      input  status, status_valid, fault, fault_ch, scan_count,
`ifdef POWER_MONITOR_FAULT_LOG_EN
      input  fault_scan,
`endif
      input  state
   );
endinterface

// File: rtl/power_monitor_vote.sv
// power_monitor_vote: 3-sample majority voter for the comparator input.
// Handshake: result_valid is a single-cycle qualifier for result, raised
// the cycle after the third sample strobe; there is no ready/backpressure,
// the consumer must take result in that cycle. clr discards partial votes.
module power_monitor_vote
   import power_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic data,
   input  logic sample,
   output logic result,
   output logic result_valid
);
   logic [1:0] cnt_q, cnt_d;
   logic       s0_q, s0_d;
   logic       s1_q, s1_d;
   logic       res_q, res_d;
   logic       vld_q, vld_d;

   // Collect two samples, vote on the third one as it arrives.
   always_comb begin
      cnt_d = cnt_q;
      s0_d  = s0_q;
      s1_d  = s1_q;
      res_d = res_q;
      vld_d = 1'b0;
      if (clr) begin
         cnt_d = 2'd0;
      end else if (sample) begin
         case (cnt_q)
            2'd0: begin
               s0_d  = data;
               cnt_d = 2'd1;
            end
            2'd1: begin
               s1_d  = data;
               cnt_d = 2'd2;
            end
            default: begin
               res_d = maj3(s0_q, s1_q, data);
               vld_d = 1'b1;
               cnt_d = 2'd0;
            end
         endcase
      end
   end

   // Voter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         s0_q  <= 1'b0;
         s1_q  <= 1'b0;
         res_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         s0_q  <= s0_d;
         s1_q  <= s1_d;
         res_q <= res_d;
         vld_q <= vld_d;
      end
   end

   assign result       = res_q;
   assign result_valid = vld_q;
endmodule

// File: rtl/power_monitor.sv
// power_monitor: steps through the channel selected by the power-management
// stage, waits for the rail to settle, votes three comparator samples and
// records per-channel good/fault status plus a completed-scan counter.
// Optional macro POWER_MONITOR_FAULT_LOG_EN adds fault_scan, the scan_count
// value captured together with fault_ch.
module power_monitor
   import power_pkg::*;
#(
   parameter logic [9:0] SETTLE_CYCLES = 10'd512,
   parameter int         NUM_CH        = NUM_CH_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   power_monitor_if.slave  bus
);
   localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

   logic [1:0]        rst_sync_q, rst_sync_d;
   logic              rst_n;
   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [9:0]        cnt_q, cnt_d;
   logic [1:0]        samp_q, samp_d;
   logic [NUM_CH-1:0] seen_q, seen_d;
   logic [NUM_CH-1:0] status_q, status_d;
   logic              fault_q, fault_d;
   logic [2:0]        fault_ch_q, fault_ch_d;
   logic [15:0]       scan_q, scan_d;
`ifdef POWER_MONITOR_FAULT_LOG_EN
   logic [15:0]       fault_scan_q, fault_scan_d;
`endif
   logic              sel_ok, sel_changed, restart, sample, pass;
   logic              vote_result, vote_valid;

   // Reset shift chain: clears immediately, releases two clocks later.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   // Reset synchroniser flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n       = rst_sync_q[1];
   assign sel_ok      = ({29'd0, bus.sel} < 32'(NUM_CH));
   assign sel_changed = (bus.sel != sel_q);

   power_monitor_vote u_vote (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (state_q != ST_SAMPLE),
      .data         (bus.data),
      .sample       (sample),
      .result       (vote_result),
      .result_valid (vote_valid)
   );

   // Sequencer next state plus status / fault / scan bookkeeping.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      samp_d     = samp_q;
      seen_d     = seen_q;
      status_d   = status_q;
      fault_d    = fault_q;
      fault_ch_d = fault_ch_q;
      scan_d     = scan_q;
`ifdef POWER_MONITOR_FAULT_LOG_EN
      fault_scan_d = fault_scan_q;
`endif
      restart = 1'b0;
      sample  = 1'b0;
      pass    = 1'b0;

      if (!bus.kill_sw) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               restart = 1'b1;
               seen_d  = '0;
            end
            ST_SETTLE: begin
               if (sel_changed)                          restart = 1'b1;
               else if (cnt_q == SETTLE_CYCLES - 10'd1)  state_d = ST_SAMPLE;
               else                                      cnt_d   = cnt_q + 10'd1;
            end
            ST_SAMPLE: begin
               if (sel_changed) begin
                  restart = 1'b1;
               end else begin
                  sample = 1'b1;
                  if (samp_q == 2'd2) state_d = ST_WAIT;
                  else                samp_d  = samp_q + 2'd1;
               end
            end
            default: begin
               if (sel_changed) restart = 1'b1;
            end
         endcase
      end

      // An out-of-range channel is latched but parked in WAIT unchecked.
      if (restart) begin
         sel_d   = bus.sel;
         cnt_d   = 10'd0;
         samp_d  = 2'd0;
         state_d = sel_ok ? ST_SETTLE : ST_WAIT;
      end

      if (bus.clear) begin
         fault_d    = 1'b0;
         fault_ch_d = 3'd0;
`ifdef POWER_MONITOR_FAULT_LOG_EN
         fault_scan_d = 16'd0;
`endif
      end

      // A completed vote overrides a coincident clear.
      if (vote_valid && bus.kill_sw) begin
         pass = (vote_result == expect_level(sel_q[0]));
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == 3'(i)) begin
               status_d[i] = pass;
               seen_d[i]   = 1'b1;
            end
         end
         if (!pass) begin
            fault_d = 1'b1;
            if (!fault_q || bus.clear) begin
               fault_ch_d = sel_q;
`ifdef POWER_MONITOR_FAULT_LOG_EN
               fault_scan_d = scan_q;
`endif
            end
         end
         if (sel_q == LAST_CH && scan_q != 16'hFFFF) scan_d = scan_q + 16'd1;
      end
   end

   // Sequencer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= 3'd0;
         cnt_q      <= 10'd0;
         samp_q     <= 2'd0;
         seen_q     <= '0;
         status_q   <= '0;
         fault_q    <= 1'b0;
         fault_ch_q <= 3'd0;
         scan_q     <= 16'd0;
`ifdef POWER_MONITOR_FAULT_LOG_EN
         fault_scan_q <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         samp_q     <= samp_d;
         seen_q     <= seen_d;
         status_q   <= status_d;
         fault_q    <= fault_d;
         fault_ch_q <= fault_ch_d;
         scan_q     <= scan_d;
`ifdef POWER_MONITOR_FAULT_LOG_EN
         fault_scan_q <= fault_scan_d;
`endif
      end
   end

   assign bus.status       = status_q;
   assign bus.status_valid = &seen_q;
   assign bus.fault        = fault_q;
   assign bus.fault_ch     = fault_ch_q;
   assign bus.scan_count   = scan_q;
   assign bus.state        = state_q;
`ifdef POWER_MONITOR_FAULT_LOG_EN
   assign bus.fault_scan   = fault_scan_q;
`endif
endmodule

// File: tb/tb_power_monitor.sv
// tb_power_monitor: scenario tasks for power_monitor with SETTLE_CYCLES=4.
// A reference model computes the expected observation word when each
// channel step is driven; it is queued and compared once the step completes.
module tb_power_monitor;
   import power_pkg::*;

   localparam int W = 28;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [W-1:0] exp_q[$];

   logic [6:0]  m_status = '0;
   logic [6:0]  m_seen = '0;
   logic        m_fault = 1'b0;
   logic [2:0]  m_fault_ch = '0;
   logic [15:0] m_scan = '0;
   logic [15:0] m_fault_scan = '0;

   power_monitor_if #(.NUM_CH(7)) bus ();

   power_monitor #(.SETTLE_CYCLES(10'd4), .NUM_CH(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // clock / reset
   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [W-1:0] pack(input logic [6:0] st, input logic v, input logic f,
                                         input logic [2:0] fc, input logic [15:0] sc);
      return {st, v, f, fc, sc};
   endfunction

   function automatic logic [W-1:0] model_word();
      return pack(m_status, (m_seen == 7'h7F), m_fault, m_fault_ch, m_scan);
   endfunction

   function automatic logic [W-1:0] dut_word();
      return pack(bus.status, bus.status_valid, bus.fault, bus.fault_ch, bus.scan_count);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour of one completed check on channel ch.
   task automatic model_check(input logic [2:0] ch, input logic [2:0] smp, input bit clr);
      int  ones;
      bit  maj, good;
      ones = int'(smp[0]) + int'(smp[1]) + int'(smp[2]);
      maj  = (ones >= 2);
      good = (ch % 2 == 0) ? maj : !maj;
      if (clr) begin
         m_fault = 1'b0;
         m_fault_ch = 3'd0;
         m_fault_scan = 16'd0;
      end
      m_status[ch] = good;
      m_seen[ch] = 1'b1;
      if (!good) begin
         if (!m_fault) begin
            m_fault_ch = ch;
            m_fault_scan = m_scan;
         end
         m_fault = 1'b1;
      end
      if (ch == 3'd6 && m_scan != 16'hFFFF) m_scan = m_scan + 16'd1;
   endtask

   // Drive one 10-cycle channel step; smp[0..2] are the three sampled levels.
   // With clr set, a clear pulse lands on the cycle the result is written.
   task automatic run_ch(input logic [2:0] ch, input logic [2:0] smp, input bit clr, input string name);
      logic [W-1:0] exp_w;
      bus.sel = ch;
      bus.data = smp[0];
      bus.clear = 1'b0;
      if (ch < 3'd7) model_check(ch, smp, clr);
      exp_q.push_back(model_word());
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 6) bus.data = smp[1];
         if (e == 7) bus.data = smp[2];
         if (clr && e == 8) bus.clear = 1'b1;
         if (clr && e == 9) bus.clear = 1'b0;
      end
      exp_w = exp_q.pop_front();
      total++;
      if (dut_word() !== exp_w) begin
         bad++;
         $display("FAIL %s: got {status,valid,fault,fault_ch,scan}=%h want %h", name, dut_word(), exp_w);
      end
`ifdef POWER_MONITOR_FAULT_LOG_EN
      total++;
      if (bus.fault_scan !== m_fault_scan) begin
         bad++;
         $display("FAIL %s fault_scan: got %0d want %0d", name, bus.fault_scan, m_fault_scan);
      end
`endif
   endtask

   task automatic model_reset();
      m_status = '0;
      m_seen = '0;
      m_fault = 1'b0;
      m_fault_ch = '0;
      m_scan = '0;
      m_fault_scan = '0;
   endtask

   task automatic test_reset();
      bus.sel = 3'd0;
      bus.data = 1'b0;
      bus.kill_sw = 1'b0;
      bus.clear = 1'b0;
      #5 reset_n = 1'b0;
      tick();
      tick();
      total++;
      if (dut_word() !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", dut_word());
      end
      total++;
      if (bus.state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE);
      end
      reset_n = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_sweep_good();
      bus.kill_sw = 1'b1;
      m_seen = '0;
      for (int c = 0; c < 7; c++) begin
         run_ch(3'(c), (c % 2 == 0) ? 3'b111 : 3'b000, 1'b0, $sformatf("sweep_good_ch%0d", c));
      end
      total++;
      if (bus.status !== 7'h7F || bus.status_valid !== 1'b1) begin
         bad++;
         $display("FAIL sweep_good_final: status=%h valid=%b want 7f 1", bus.status, bus.status_valid);
      end
      total++;
      if (bus.fault !== 1'b0 || bus.scan_count !== 16'd1) begin
         bad++;
         $display("FAIL sweep_good_fault_scan: fault=%b scan=%0d want 0 1", bus.fault, bus.scan_count);
      end
   endtask

   task automatic test_sweep_fault_clear();
      for (int c = 0; c < 7; c++) begin
         run_ch(3'(c), (c % 2 == 0 && c != 2) ? 3'b111 : 3'b000, 1'b0, $sformatf("sweep_fault_ch%0d", c));
      end
      total++;
      if (bus.status[2] !== 1'b0 || bus.fault !== 1'b1 || bus.fault_ch !== 3'd2) begin
         bad++;
         $display("FAIL sweep_fault_final: status2=%b fault=%b fault_ch=%0d want 0 1 2",
                  bus.status[2], bus.fault, bus.fault_ch);
      end
      bus.clear = 1'b1;
      m_fault = 1'b0;
      m_fault_ch = 3'd0;
      m_fault_scan = 16'd0;
      tick();
      bus.clear = 1'b0;
      tick();
      total++;
      if (dut_word() !== model_word() || bus.status !== 7'h7B) begin
         bad++;
         $display("FAIL clear_pulse: got %h want %h", dut_word(), model_word());
      end
   endtask

   task automatic test_glitch();
      run_ch(3'd1, 3'b010, 1'b0, "glitch_010_pass");
      run_ch(3'd7, 3'b000, 1'b0, "sel_out_of_range");
      total++;
      if (bus.state !== ST_WAIT) begin
         bad++;
         $display("FAIL sel_out_of_range_state: got %0d want %0d", bus.state, ST_WAIT);
      end
      run_ch(3'd1, 3'b101, 1'b0, "glitch_101_fail");
      total++;
      if (bus.fault !== 1'b1 || bus.fault_ch !== 3'd1) begin
         bad++;
         $display("FAIL glitch_fault: fault=%b fault_ch=%0d want 1 1", bus.fault, bus.fault_ch);
      end
   endtask

   task automatic test_abort();
      // Abort 2 cycles into SETTLE with failing data on channel 4.
      bus.sel = 3'd4;
      bus.data = 1'b0;
      for (int e = 0; e < 3; e++) tick();
      run_ch(3'd5, 3'b000, 1'b0, "abort_settle_then_ch5");
      // Abort after two samples have been taken.
      bus.sel = 3'd4;
      bus.data = 1'b0;
      for (int e = 0; e < 7; e++) tick();
      run_ch(3'd3, 3'b000, 1'b0, "abort_sample_then_ch3");
      total++;
      if (bus.status[4] !== 1'b1) begin
         bad++;
         $display("FAIL abort_no_write: status4=%b want 1", bus.status[4]);
      end
   endtask

   task automatic test_clear_coincident();
      run_ch(3'd6, 3'b000, 1'b1, "clear_with_fail_ch6");
      total++;
      if (bus.fault !== 1'b1 || bus.fault_ch !== 3'd6) begin
         bad++;
         $display("FAIL clear_coincident: fault=%b fault_ch=%0d want 1 6", bus.fault, bus.fault_ch);
      end
   endtask

   task automatic test_kill();
      bus.sel = 3'd2;
      bus.data = 1'b0;
      for (int e = 0; e < 6; e++) tick();
      bus.kill_sw = 1'b0;
      tick();
      total++;
      if (bus.state !== ST_IDLE) begin
         bad++;
         $display("FAIL kill_idle: state=%0d want %0d", bus.state, ST_IDLE);
      end
      for (int e = 0; e < 4; e++) tick();
      total++;
      if (dut_word() !== model_word()) begin
         bad++;
         $display("FAIL kill_hold: got %h want %h", dut_word(), model_word());
      end
      bus.kill_sw = 1'b1;
      m_seen = '0;
      run_ch(3'd2, 3'b111, 1'b0, "kill_resume_ch2");
   endtask

   task automatic test_reset_mid_scan();
      bus.sel = 3'd3;
      bus.data = 1'b0;
      for (int e = 0; e < 4; e++) tick();
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      total++;
      if (dut_word() !== '0 || bus.state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_mid_scan: got %h state=%0d want 0 IDLE", dut_word(), bus.state);
      end
`ifdef POWER_MONITOR_FAULT_LOG_EN
      total++;
      if (bus.fault_scan !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid_scan fault_scan: got %0d want 0", bus.fault_scan);
      end
`endif
      bus.kill_sw = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      for (int e = 0; e < 4; e++) tick();
      bus.kill_sw = 1'b1;
      run_ch(3'd0, 3'b111, 1'b0, "after_reset_ch0");
   endtask

   initial begin
      test_reset();
      test_sweep_good();
      test_sweep_fault_clear();
      test_glitch();
      test_abort();
      test_clear_coincident();
      test_kill();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
